// File: rtl/keccak_msg_tx_pkg.sv
// Shared widths, encodings and helpers for the keccak message transmitter.
package keccak_msg_tx_pkg;
  localparam int BW_DATA  = 64;
  localparam int BW_IBLEN = 11;
  localparam int BW_OBLEN = 10;
  localparam int BW_ADDR  = 8;
  localparam int BW_NW    = BW_ADDR + 1;  // NW can reach 256

  typedef enum logic [1:0] {
    MODE_SHA3_256 = 2'd0,
    MODE_SHA3_512 = 2'd1,
    MODE_SHAKE128 = 2'd2,
    MODE_SHAKE256 = 2'd3
  } kmode_e;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_STREAM, S_WAIT_HI, S_WAIT_LO, S_FIN
  } tx_state_e;

  function automatic logic [BW_NW-1:0] nw_f(input logic [BW_IBLEN-1:0] len);
    logic [BW_IBLEN:0] t;
    t = {1'b0, len} + (BW_IBLEN+1)'(7);
    return t[BW_IBLEN:3];
  endfunction

  // Keeps the top rem bytes of a left-aligned partial word; rem==0 means full word.
  function automatic logic [BW_DATA-1:0] tail_mask_f(input logic [2:0] rem);
    if (rem == 3'd0) return '1;
    return ~({BW_DATA{1'b1}} >> {rem, 3'b000});
  endfunction
endpackage

// File: rtl/keccak_msg_tx_if.sv
// Absorb-side bus between the message transmitter (master) and keccak (slave).
interface keccak_msg_tx_if;
  import keccak_msg_tx_pkg::*;
  logic [1:0]          o_mode;
  logic [BW_DATA-1:0]  o_ibytes;
  logic                o_ibytes_valid;
  logic [BW_IBLEN-1:0] o_ibytes_len;
  logic [BW_OBLEN-1:0] o_obytes_len;
  logic                i_ibytes_ready;
  logic                i_obytes_valid;

  modport master (
    output o_mode, o_ibytes, o_ibytes_valid, o_ibytes_len, o_obytes_len,
    input  i_ibytes_ready, i_obytes_valid
  );
  modport slave (
    input  o_mode, o_ibytes, o_ibytes_valid, o_ibytes_len, o_obytes_len,
    output i_ibytes_ready, i_obytes_valid
  );
endinterface

// File: rtl/keccak_msg_skid.sv
// 2-entry skid buffer fed by a 1-cycle-latency memory; tracks the in-flight read as a credit.
module keccak_msg_skid
  import keccak_msg_tx_pkg::*;
#(
  parameter int BW = BW_DATA
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          issue_i,
  input  logic [BW-1:0] wr_data_i,
  output logic          rd_valid_o,
  output logic [BW-1:0] rd_data_o,
  input  logic          rd_ready_i,
  output logic          room_o
);
  logic          pend_q;
  logic [1:0]    cnt_q, cnt_d;
  logic [BW-1:0] buf0_q, buf1_q;
  logic          xfer, pop, push;

  // Arriving data bypasses straight to the output when the buffer is empty.
  always_comb begin
    rd_valid_o = (cnt_q != 2'd0) || pend_q;
    rd_data_o  = (cnt_q != 2'd0) ? buf0_q : (pend_q ? wr_data_i : '0);
    xfer       = rd_valid_o && rd_ready_i;
    pop        = xfer && (cnt_q != 2'd0);
    push       = pend_q && !(xfer && (cnt_q == 2'd0));
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
    room_o     = (({1'b0, cnt_q} + {2'b0, pend_q}) - {2'b0, xfer}) < 3'd2;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_q <= 1'b0;
      cnt_q  <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      pend_q <= issue_i;
      cnt_q  <= cnt_d;
      if (pop) begin
        buf0_q <= (cnt_q == 2'd2) ? buf1_q : wr_data_i;
      end else if (push) begin
        if (cnt_q == 2'd0) buf0_q <= wr_data_i;
        else               buf1_q <= wr_data_i;
      end
    end
  end
endmodule

// File: rtl/keccak_msg_tx.sv
// Reads a message from word memory, streams it into keccak, then waits out the squeeze.
module keccak_msg_tx
  import keccak_msg_tx_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic [1:0]          i_mode,
  input  logic [BW_IBLEN-1:0] i_ibytes_len,
  input  logic [BW_OBLEN-1:0] i_obytes_len,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic                o_mem_ren,
  output logic [BW_ADDR-1:0]  o_mem_addr,
  input  logic [BW_DATA-1:0]  i_mem_rdata,
  keccak_msg_tx_if.master     kif
);
  tx_state_e           state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [BW_IBLEN-1:0] ilen_q, ilen_d;
  logic [BW_OBLEN-1:0] olen_q, olen_d;
  logic [BW_NW-1:0]    nw_q, nw_d, rd_cnt_q, rd_cnt_d, tx_cnt_q, tx_cnt_d;
  logic                err_q, err_d, last_q, last_d;
  logic                room, xfer, sk_valid;
  logic [BW_DATA-1:0]  sk_data, wr_data;

  assign wr_data = last_q ? (i_mem_rdata & tail_mask_f(ilen_q[2:0])) : i_mem_rdata;

  keccak_msg_skid #(.BW(BW_DATA)) u_skid (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .issue_i    (o_mem_ren),
    .wr_data_i  (wr_data),
    .rd_valid_o (sk_valid),
    .rd_data_o  (sk_data),
    .rd_ready_i (kif.i_ibytes_ready),
    .room_o     (room)
  );

  assign kif.o_ibytes_valid = sk_valid;
  assign kif.o_ibytes       = sk_data;
  assign kif.o_mode         = mode_q;
  assign kif.o_ibytes_len   = ilen_q;
  assign kif.o_obytes_len   = olen_q;
  assign o_mem_addr         = rd_cnt_q[BW_ADDR-1:0];
  assign o_err              = o_done && err_q;
  assign xfer               = sk_valid && kif.i_ibytes_ready;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    ilen_d    = ilen_q;
    olen_d    = olen_q;
    nw_d      = nw_q;
    rd_cnt_d  = rd_cnt_q;
    tx_cnt_d  = tx_cnt_q;
    err_d     = err_q;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    o_mem_ren = 1'b0;
    unique case (state_q)
      S_IDLE: if (i_start) begin
        mode_d   = i_mode;
        ilen_d   = i_ibytes_len;
        olen_d   = i_obytes_len;
        nw_d     = nw_f(i_ibytes_len);
        rd_cnt_d = '0;
        tx_cnt_d = '0;
        err_d    = 1'b0;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        o_busy    = 1'b1;
        o_mem_ren = (rd_cnt_q < nw_q) && room;
        if (nw_q == '0) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        o_busy    = 1'b1;
        o_mem_ren = (rd_cnt_q < nw_q) && room;
        if (xfer) begin
          tx_cnt_d = tx_cnt_q + 1'b1;
          if (tx_cnt_q == nw_q - 1'b1) state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        o_busy = 1'b1;
        if (kif.i_obytes_valid) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        o_busy = 1'b1;
        if (!kif.i_obytes_valid) state_d = S_FIN;
      end
      S_FIN: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (o_mem_ren) rd_cnt_d = rd_cnt_q + 1'b1;
    last_d = o_mem_ren && (rd_cnt_q == nw_q - 1'b1);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      ilen_q   <= '0;
      olen_q   <= '0;
      nw_q     <= '0;
      rd_cnt_q <= '0;
      tx_cnt_q <= '0;
      err_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      ilen_q   <= ilen_d;
      olen_q   <= olen_d;
      nw_q     <= nw_d;
      rd_cnt_q <= rd_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      err_q    <= err_d;
      last_q   <= last_d;
    end
  end
endmodule

// File: tb/tb_keccak_msg_tx.sv
// Self-checking bench for keccak_msg_tx: table of jobs, random jobs, reset abort.
module tb_keccak_msg_tx;
  import keccak_msg_tx_pkg::*;

  logic                clk, rstn, start;
  logic [1:0]          mode;
  logic [BW_IBLEN-1:0] ilen;
  logic [BW_OBLEN-1:0] olen;
  logic                busy, done, err, ren;
  logic [BW_ADDR-1:0]  addr;
  logic [BW_DATA-1:0]  rdata;

  keccak_msg_tx_if kif();

  keccak_msg_tx dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_mode(mode),
    .i_ibytes_len(ilen), .i_obytes_len(olen),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_mem_ren(ren), .o_mem_addr(addr), .i_mem_rdata(rdata),
    .kif(kif.master)
  );

  logic [63:0] mem   [256];
  logic [63:0] exp_w [256];
  int errors = 0, checks = 0, cyc = 0, rpat = 0;
  int cur_nw, cur_len, cur_olen, cur_mode;
  int m_rd, m_tx, m_first, done_cnt = 0, done_cyc = 0;
  bit mon_en = 0, prev_stall = 0, done_err = 0;
  logic [63:0] prev_data;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end
  initial begin #800000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  always @(posedge clk) if (ren) rdata <= mem[addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Ready pattern: 0 always, 1 toggle, 2 random, 3 toggle with random stalls.
  initial forever begin
    @(posedge clk); #1;
    case (rpat)
      0: kif.i_ibytes_ready = 1'b1;
      1: kif.i_ibytes_ready = ~kif.i_ibytes_ready;
      2: kif.i_ibytes_ready = ($urandom_range(0, 3) != 0);
      default: kif.i_ibytes_ready = ~kif.i_ibytes_ready & ($urandom_range(0, 4) != 0);
    endcase
  end

  // Monitor: samples on the falling edge, compares with the expectation built in prep_job.
  initial forever begin
    @(negedge clk);
    if (mon_en && rstn) begin
      if (ren) begin
        chk("rd_addr", 64'(addr), 64'(m_rd));
        chk("rd_range", 64'(m_rd < cur_nw), 64'd1);
        m_rd++;
      end
      if (prev_stall) begin
        chk("hold_vld", 64'(kif.o_ibytes_valid), 64'd1);
        chk("hold_data", kif.o_ibytes, prev_data);
      end
      if (kif.o_ibytes_valid && m_first < 0) m_first = cyc;
      if (kif.o_ibytes_valid && kif.i_ibytes_ready) begin
        if (m_tx < cur_nw) chk("word", kif.o_ibytes, exp_w[m_tx]);
        else               chk("extra_xfer", 64'(m_tx), 64'(cur_nw));
        m_tx++;
      end
      chk("outstanding", 64'((m_rd - m_tx) <= 2), 64'd1);
      if (busy)
        chk("captured", {kif.o_mode, kif.o_ibytes_len, kif.o_obytes_len},
            {2'(cur_mode), 11'(cur_len), 10'(cur_olen)});
      prev_stall = kif.o_ibytes_valid && !kif.i_ibytes_ready;
      prev_data  = kif.o_ibytes;
      if (done) begin done_cnt++; done_cyc = cyc; done_err = err; end
    end
  end

  task automatic prep_job(input int len, input int ol, input int md, input int rp, input bit ones);
    int nw;
    nw = (len + 7) / 8;
    for (int k = 0; k < 256; k++) mem[k] = {$urandom, $urandom};
    if (ones && nw > 0) mem[nw-1] = '1;
    // Byte b of the message lives in word b/8, byte lane b%8 counted from the MSB.
    for (int k = 0; k < nw; k++)
      for (int j = 0; j < 8; j++)
        exp_w[k][63-8*j -: 8] = (8*k + j < len) ? mem[k][63-8*j -: 8] : 8'h00;
    cur_nw = nw; cur_len = len; cur_olen = ol; cur_mode = md;
    m_rd = 0; m_tx = 0; m_first = -1; prev_stall = 0; rpat = rp; mon_en = 1;
  endtask

  task automatic pulse_start(output int t0);
    @(posedge clk); #1;
    start = 1; ilen = 11'(cur_len); olen = 10'(cur_olen); mode = 2'(cur_mode); t0 = cyc;
    @(posedge clk); #1;
    start = 0; ilen = 11'($urandom); olen = 10'($urandom); mode = 2'($urandom);
  endtask

  task automatic run_job(input int len, input int ol, input int md, input int rp, input bit early,
                         input bit poke, input bit ones, output int ntx, output bit err_o);
    int t0, d_cyc, dc0, lim;
    bit poked;
    poked = 0; d_cyc = 0;
    prep_job(len, ol, md, rp, ones);
    dc0 = done_cnt;
    kif.i_obytes_valid = early;
    pulse_start(t0);
    lim = 0;
    while (m_tx < cur_nw && lim < 6000) begin
      @(posedge clk); #1;
      start = 0;
      if (poke && !poked && m_tx >= 1) begin
        start = 1; ilen = 11'(len + 100); olen = 10'(ol + 3); mode = 2'(md + 1); poked = 1;
      end
      lim++;
    end
    start = 0;
    chk("xfer_timeout", 64'(lim < 6000), 64'd1);
    if (cur_nw > 0) begin
      kif.i_obytes_valid = 1;
      repeat (3) @(posedge clk);
      #1 kif.i_obytes_valid = 0;
      d_cyc = cyc;
    end
    lim = 0;
    while (done_cnt == dc0 && lim < 50) begin @(negedge clk); #1; lim++; end
    chk("done_seen", 64'(done_cnt - dc0), 64'd1);
    if (cur_nw > 0) begin
      chk("done_lat", 64'(done_cyc - d_cyc), 64'd1);
      chk("first_vld_lat", 64'(m_first - t0), 64'd2);
    end else begin
      chk("done_lat", 64'(done_cyc - t0), 64'd2);
      chk("no_vld", 64'(m_first < 0), 64'd1);
    end
    chk("n_rd", 64'(m_rd), 64'(cur_nw));
    @(negedge clk); #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_keep", {kif.o_mode, kif.o_ibytes_len, kif.o_obytes_len},
        {2'(md), 11'(len), 10'(ol)});
    ntx = m_tx; err_o = done_err;
  endtask

  typedef struct {
    int len; int olen; int mode; int rp; bit early; bit poke; bit ones;
    int exp_nw; bit exp_err;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int ntx, t0, lim;
    bit e;
    vecs[0] = '{32,   32,   0, 0, 0, 0, 0, 4,   0};
    vecs[1] = '{33,   64,   2, 0, 0, 0, 1, 5,   0};
    vecs[2] = '{1184, 784,  3, 3, 0, 0, 0, 148, 0};
    vecs[3] = '{0,    32,   1, 0, 0, 0, 0, 0,   1};
    vecs[4] = '{40,   100,  1, 2, 0, 1, 0, 5,   0};
    vecs[5] = '{1,    16,   2, 1, 1, 0, 1, 1,   0};
    vecs[6] = '{2047, 1023, 3, 2, 0, 0, 1, 256, 0};
    vecs[7] = '{8,    32,   0, 0, 0, 0, 1, 1,   0};

    rstn = 0; start = 0; mode = 0; ilen = 0; olen = 0;
    kif.i_ibytes_ready = 0; kif.i_obytes_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 64'({busy, done, err, ren, addr, kif.o_mode, kif.o_ibytes_valid,
                        kif.o_ibytes_len, kif.o_obytes_len}), 64'd0);
    chk("rst_data", kif.o_ibytes, 64'd0);
    rstn = 1;

    foreach (vecs[i]) begin
      run_job(vecs[i].len, vecs[i].olen, vecs[i].mode, vecs[i].rp, vecs[i].early,
              vecs[i].poke, vecs[i].ones, ntx, e);
      chk($sformatf("vec%0d_nw", i), 64'(ntx), 64'(vecs[i].exp_nw));
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
    end

    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 200);
      run_job(len, $urandom_range(0, 784), $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom), 0, 1'($urandom), ntx, e);
      chk("rand_nw", 64'(ntx), 64'((len + 7) / 8));
      chk("rand_err", 64'(e), 64'd0);
    end

    // Abort a 4-word job after its second transfer with an asynchronous reset.
    prep_job(32, 48, 1, 0, 0);
    pulse_start(t0);
    lim = 0;
    while (m_tx < 2 && lim < 100) begin @(negedge clk); #1; lim++; end
    chk("abort_reach", 64'(m_tx), 64'd2);
    mon_en = 0;
    rstn = 0;
    #1;
    chk("abort_ctl", 64'({busy, done, err, ren, addr, kif.o_mode, kif.o_ibytes_valid,
                          kif.o_ibytes_len, kif.o_obytes_len}), 64'd0);
    chk("abort_data", kif.o_ibytes, 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("post_abort", 64'({busy, done, ren}), 64'd0);
    end
    run_job(64, 32, 3, 0, 0, 0, 0, ntx, e);
    chk("restart_nw", 64'(ntx), 64'd8);
    chk("restart_err", 64'(e), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keccak_msg_tx.md
Name: keccak_msg_tx

Overview:
- Transmit side of the keccak absorb interface.
- On a start command, reads a message from a synchronous word memory and streams it to keccak as 64-bit words on i_ibytes/i_ibytes_valid/i_ibytes_ready. Also presents mode and the in/out byte lengths.
- Waits for keccak's squeeze output to complete, then signals done.
- Sits between the Kyber controller's message buffers and keccak.

Parameters:
- BW_DATA, 64, word width (fixed at 64).
- BW_IBLEN, 11, width of input byte length (max 1184 B used, 2047 representable).
- BW_OBLEN, 10, width of output byte length (max 784 B).
- BW_ADDR, 8, message memory word address width (up to 256 words).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start request; ignored while o_busy=1.
- i_mode  in  2  keccak mode; captured at start.
- i_ibytes_len  in  BW_IBLEN  message length in bytes; captured at start.
- i_obytes_len  in  BW_OBLEN  requested output bytes; captured at start.
- o_busy  out  1  high from accepted start until o_done.
- o_done  out  1  one-cycle pulse at end of job.
- o_err  out  1  valid with o_done; 1 = job rejected (length 0).
- o_mem_ren  out  1  memory read enable.
- o_mem_addr  out  BW_ADDR  memory word address.
- i_mem_rdata  in  BW_DATA  read data, valid exactly 1 cycle after o_mem_ren.
- o_mode  out  2  to keccak i_mode.
- o_ibytes  out  BW_DATA  to keccak i_ibytes.
- o_ibytes_valid  out  1  to keccak i_ibytes_valid.
- o_ibytes_len  out  BW_IBLEN  to keccak i_ibytes_len.
- o_obytes_len  out  BW_OBLEN  to keccak i_obytes_len.
- i_ibytes_ready  in  1  from keccak o_ibytes_ready.
- i_obytes_valid  in  1  from keccak o_obytes_valid.

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE, counters and skid buffer cleared.
  - Reset mid-job aborts immediately: no o_done, and memory reads stop.
- Word count: NW = ceil(len/8).
- Word order:
  - Memory word k holds message bytes 8k..8k+7.
  - The first byte is in [63:56] (MSB-first, matching keccak's expected ordering).
  - A partial last word is left-aligned; unused low bytes are driven 0 by this block regardless of memory content.
- States: IDLE, CHECK, STREAM, WAIT_HI, WAIT_LO, FIN.
- IDLE:
  - When i_start=1, capture mode and lengths and set o_busy.
  - Go to CHECK.
- CHECK:
  - If len==0, go to FIN with o_err=1.
  - Otherwise issue read addr 0 and go to STREAM.
- STREAM:
  - o_ibytes_valid=1 whenever the 2-entry skid buffer is non-empty.
  - A word transfers when o_ibytes_valid && i_ibytes_ready.
  - o_ibytes and o_ibytes_valid stay stable until transfer.
  - A new read is issued only if the buffer has room counting in-flight reads; never more than 2 outstanding words.
  - Throughput is 1 word/cycle under continuous ready.
  - First o_ibytes_valid occurs 2 cycles after start (CHECK + read latency).
  - Addresses increment 0..NW-1; no read is issued beyond NW-1.
  - After the final transfer, drop valid and go to WAIT_HI.
- WAIT_HI: wait for i_obytes_valid=1, then go to WAIT_LO.
- WAIT_LO: wait for i_obytes_valid=0, then go to FIN.
- FIN: o_done=1 for one cycle, o_busy drops in the same cycle, go to IDLE.
- o_mode, o_ibytes_len and o_obytes_len:
  - Held stable from CHECK through FIN.
  - Keep their last values in IDLE.
- Simultaneous events:
  - i_start in the FIN cycle is ignored; the next start is accepted in IDLE.
  - i_obytes_valid already high on entry to WAIT_HI is legal: advance the next cycle.
- No combinational path from i_ibytes_ready to o_ibytes_valid or o_ibytes.
  - o_mem_ren may depend combinationally on i_ibytes_ready.

Decomposition:
- Shared package/defines (keccak_defines):
  - BW_DATA, BW_IBLEN, BW_OBLEN.
  - Mode encodings (SHA3-256, SHA3-512, SHAKE128, SHAKE256).
  - State localparams.
  - NW computation as a function.
- One sub-module: keccak_msg_skid, a 2-entry valid/ready skid buffer with in-flight credit count, BW_DATA wide.

Test Plan:
- len=32, ready=1: addresses 0..3 are read, and 4 consecutive valid cycles start 2 cycles after start. Words equal mem[0..3]. o_done follows the falling edge of i_obytes_valid (model high for 3 cycles) by 1 cycle, with o_err=0.
- len=33: NW=5. Word 4 equals {mem[4][63:56], 56'h0} even when mem[4]=64'hFFFF_FFFF_FFFF_FFFF.
- len=1184 with ready toggling 1010… and random stalls: exactly 148 transfers in order. Words are held stable during stalls, at most 2 reads are outstanding, and no address exceeds 147.
- len=0: o_done=1 and o_err=1 two cycles after start; o_ibytes_valid and o_mem_ren never assert.
- i_start pulsed during STREAM with different len: ignored, and the captured length and outputs are unchanged.
- Reset asserted mid-STREAM (after word 2 of 4): all outputs are 0 asynchronously. A new start with len=64 then completes normally with 8 words from addr 0.
